seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
Parametrised time-multiplexed driver for an N-digit common-select seven-segment display; successor to the fixed 4-digit scanner used by the parking system. Adds configurable digit count and refresh rate, hex or decimal decode, leading-zero blanking, per-digit decimal points, frame-coherent input snapshot and a frame-done strobe. Sits between the status/counter logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
REFRESH_DIV, 1024, clk cycles each digit is held; legal range >= 2.
HEX_MODE, 0, 1: nibble values 10..15 shown as A..F. 0: values 10..15 shown blank.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
value  input  4*NUM_DIGITS  packed nibbles; value[4i+3:4i] is digit i, digit 0 least significant
dp_mask  input  NUM_DIGITS  bit i lights the decimal point of digit i
blank_lz  input  1  enables leading-zero blanking
seg_data  output  8  segment drive, active-high; bit0=a .. bit6=g, bit7=dp
dig_sel  output  NUM_DIGITS  one-hot digit select, active-high; bit i selects digit i
frame_done  output  1  one-cycle pulse at the end of each complete scan

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: prescaler 0, digit index 0, snapshot registers 0, blink phase 0, seg_data 8'h00, dig_sel all zeros (display dark), frame_done 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler == REFRESH_DIV-1).
- On each tick the index advances: idx -> idx+1, and NUM_DIGITS-1 wraps to 0. On that same edge, seg_data and dig_sel are registered for the new index. Each digit is therefore held exactly REFRESH_DIV cycles. The first digit appears REFRESH_DIV cycles after reset release.
- Snapshot: on the tick where idx wraps to 0, value and dp_mask are loaded into snapshot registers. Digit 0 of that frame decodes from the live inputs on that edge. All later digits of the frame decode from the snapshot. Input changes mid-frame never tear a frame.
- The first frame after reset starts at idx 0 without a wrap. It decodes the live inputs for digit 0 and loads the snapshot on that first tick.
- frame_done: registered pulse, high for the single cycle following the tick on which idx wraps NUM_DIGITS-1 -> 0. It never fires during the first post-reset frame.
- Decode for nibble values 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Decode for nibble values 10..15: A=77, b=7C, C=39, d=5E, E=79, F=71 when HEX_MODE=1; 00 when HEX_MODE=0.
- Leading-zero blanking: when blank_lz=1, digit i (i>0) has segments a..g forced to 0 if its nibble and all more-significant nibbles are 0. Digit 0 is never blanked. dp (bit7) follows dp_mask regardless of blanking. blank_lz is sampled live, not snapshotted.
- dig_sel is always exactly one-hot after the first tick. Reasserting rst mid-frame immediately forces the reset values and restarts scanning from idx 0.

Optional Feature:
SEVSEG_BLINK_EN. When defined:
- Adds input blink_mask [NUM_DIGITS-1:0] (snapshotted with value) and parameter BLINK_FRAMES (default 64).
- A frame counter toggles blink phase every BLINK_FRAMES frame_done pulses.
- While phase=1, a digit whose mask bit is set outputs seg_data=00, including dp. dig_sel is unchanged.

When undefined: no port, no counter, no blink blanking.

Test Plan:
1. NUM_DIGITS=4, REFRESH_DIV=4, value=16'h1234, hold rst 3 cycles, release -> seg 00, sel 0000 for 4 cycles; then sel 0001 with seg 66.
2. Same value, full scan -> sel 0001/0010/0100/1000 with seg 66/4F/5B/06, each held 4 cycles; frame_done high one cycle after sel returns to 0001 (second frame onward).
3. Change value to 16'h5678 while sel=0010 -> remaining digits show 5B, 06; next frame shows 7F, 07, 7D, 6D.
4. value=16'h00AF, HEX_MODE=0 -> digits 0,1 seg 00, digits 2,3 seg 3F. HEX_MODE=1 -> digit0 71, digit1 77.
5. blank_lz=1, value=16'h0030, dp_mask=4'b0100 -> digit0 3F, digit1 4F, digit2 80, digit3 00. value=0 -> digit0 3F, others 00 (digit2 80).
6. With SEVSEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 -> digit0 alternates 66 for 2 frames, then 00 for 2 frames; rst pulsed mid-frame -> outputs 0 immediately and phase resets to 0.

Source files
------------

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// seven_segment_scanner: N-digit multiplexed seven-segment driver with a frame-coherent input snapshot.
// Optional per-digit blinking is built when SEVSEG_BLINK_EN is defined.  Rev 1.0
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1024,
  parameter int HEX_MODE    = 0
`ifdef SEVSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
`ifdef SEVSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  input  logic                    blank_lz,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_val_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fd_q;
  logic                    tick, started, wrap, load;
  logic [4*NUM_DIGITS-1:0] src_val, upper;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [3:0]              nib;

`ifdef SEVSEG_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] snap_blink_q, src_blink;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] h;
    case (n)
      4'h0: h = 7'h3F;
      4'h1: h = 7'h06;
      4'h2: h = 7'h5B;
      4'h3: h = 7'h4F;
      4'h4: h = 7'h66;
      4'h5: h = 7'h6D;
      4'h6: h = 7'h7D;
      4'h7: h = 7'h07;
      4'h8: h = 7'h7F;
      4'h9: h = 7'h6F;
      4'hA: h = 7'h77;
      4'hB: h = 7'h7C;
      4'hC: h = 7'h39;
      4'hD: h = 7'h5E;
      4'hE: h = 7'h79;
      default: h = 7'h71;
    endcase
    if (n > 4'd9 && HEX_MODE == 0) h = 7'h00;
    return h;
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    // An all-zero select marks the dark interval before the first frame.
    started = |sel_q;
    wrap    = started && (idx_q == IDX_LAST);
    load    = tick && (!started || wrap);
    idx_d   = idx_q;
    if (tick) idx_d = (!started || wrap) ? '0 : idx_q + IW'(1);

    // Digit 0 decodes live inputs on the same edge that loads the snapshot.
    src_val = (idx_d == '0) ? value : snap_val_q;
    src_dp  = (idx_d == '0) ? dp_mask : snap_dp_q;
    nib     = src_val[{idx_d, 2'b00} +: 4];
    upper   = src_val >> {idx_d, 2'b00};
    seg_d   = {src_dp[idx_d], decode(nib)};
    if (blank_lz && (idx_d != '0) && (upper == '0)) seg_d[6:0] = '0;

`ifdef SEVSEG_BLINK_EN
    src_blink = (idx_d == '0) ? blink_mask : snap_blink_q;
    fcnt_d    = fcnt_q;
    phase_d   = phase_q;
    if (tick && wrap) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    if (phase_d && src_blink[idx_d]) seg_d = '0;
`endif

    sel_d = NUM_DIGITS'(1) << idx_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      snap_val_q <= '0;
      snap_dp_q  <= '0;
      seg_q      <= 8'h00;
      sel_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      presc_q <= presc_d;
      fd_q    <= tick && wrap;
      if (tick) begin
        idx_q <= idx_d;
        seg_q <= seg_d;
        sel_q <= sel_d;
      end
      if (load) begin
        snap_val_q <= value;
        snap_dp_q  <= dp_mask;
      end
    end
  end

`ifdef SEVSEG_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      snap_blink_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      if (load) snap_blink_q <= blink_mask;
    end
  end
`endif

  assign seg_data   = seg_q;
  assign dig_sel    = sel_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// Randomised bench: two scanners (decimal and hex decode) against a slot/frame-level reference model.
module tb_seven_segment_scanner;
  localparam int N = 4;
  localparam int R = 4;
  localparam logic [7:0] SEG_TBL [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value;
  logic [N-1:0]  dp_mask;
  logic          blank_lz;
  logic [7:0]    seg0, seg1;
  logic [N-1:0]  sel0, sel1;
  logic          fd0, fd1;
`ifdef SEVSEG_BLINK_EN
  logic [N-1:0]  blink_mask = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int           edges;
  logic [15:0]  snap_val;
  logic [N-1:0] snap_dp;
  logic [7:0]   exp_seg0, exp_seg1;
  logic [N-1:0] exp_sel;
  logic         exp_fd;

  always #5 clk = ~clk;

  seven_segment_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0)) u_dec (
    .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask),
`ifdef SEVSEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .blank_lz(blank_lz), .seg_data(seg0), .dig_sel(sel0), .frame_done(fd0));

  seven_segment_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst(rst), .value(value), .dp_mask(dp_mask),
`ifdef SEVSEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .blank_lz(blank_lz), .seg_data(seg1), .dig_sel(sel1), .frame_done(fd1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [15:0] v, input logic [N-1:0] dp,
                                         input logic blz, input int d, input bit hex);
    int   rest;
    int   n;
    logic [7:0] s;
    rest = int'(v) >> (4 * d);
    n    = rest % 16;
    s    = (n < 10 || hex) ? SEG_TBL[n] : 8'h00;
    if (blz && d > 0 && rest == 0) s = 8'h00;
    s[7] = dp[d];
    return s;
  endfunction

  task automatic model_reset();
    edges    = 0;
    exp_seg0 = '0;
    exp_seg1 = '0;
    exp_sel  = '0;
    exp_fd   = 1'b0;
  endtask

  // Slot n (n>=1) starts at edge n*R; slot n shows digit (n-1)%N of frame (n-1)/N.
  task automatic model_step();
    int n, d;
    edges++;
    exp_fd = 1'b0;
    if (edges % R == 0) begin
      n = edges / R;
      d = (n - 1) % N;
      if (d == 0) begin
        snap_val = value;
        snap_dp  = dp_mask;
        exp_fd   = (n > 1);
      end
      exp_sel  = N'(1) << d;
      exp_seg0 = ref_seg(snap_val, snap_dp, blank_lz, d, 1'b0);
      exp_seg1 = ref_seg(snap_val, snap_dp, blank_lz, d, 1'b1);
    end
  endtask

  task automatic compare_all(input string pfx);
    check_eq({pfx, "_seg_dec"}, 32'(seg0), 32'(exp_seg0));
    check_eq({pfx, "_seg_hex"}, 32'(seg1), 32'(exp_seg1));
    check_eq({pfx, "_sel_dec"}, 32'(sel0), 32'(exp_sel));
    check_eq({pfx, "_sel_hex"}, 32'(sel1), 32'(exp_sel));
    check_eq({pfx, "_fd_dec"},  32'(fd0),  32'(exp_fd));
    check_eq({pfx, "_fd_hex"},  32'(fd1),  32'(exp_fd));
  endtask

  task automatic randomize_inputs();
    logic [15:0] v;
    if ($urandom_range(0, 5) == 0) begin
      v = '0;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
      value = v;
    end
    if ($urandom_range(0, 7) == 0) dp_mask  = N'($urandom_range(0, 15));
    if ($urandom_range(0, 9) == 0) blank_lz = 1'($urandom_range(0, 1));
  endtask

  initial begin
    value    = 16'h1234;
    dp_mask  = '0;
    blank_lz = 1'b0;
    snap_val = '0;
    snap_dp  = '0;
    rst      = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      compare_all("run");
      if (cyc == 21) begin
        value = 16'h5678;
      end else if (cyc == 60) begin
        value = 16'h00AF;
      end else if (cyc == 100) begin
        value    = 16'h0030;
        dp_mask  = 4'b0100;
        blank_lz = 1'b1;
      end else if (cyc == 140) begin
        value = 16'h0000;
      end else if (cyc == 703) begin
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all("arst");
        @(negedge clk);
        rst = 1'b0;
      end else if (cyc > 180) begin
        randomize_inputs();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
